wrq: RTL

Write request queue for the host-to-application direction of the multi-app bridge. It accepts per-application write requests announced by the host-side packet decoder and buffers them in arrival order. It issues one request at a time to the shared write engine, only when the target app's receive data queue has space, and holds off until the engine reports `write_done`. It is the write-side counterpart of the read request queue and drives the same app-selection interface towards the datapath.

---
 rtl/wrq_pkg.sv | 21 ++
 rtl/wrq_fifo.sv | 58 +++++
 rtl/wrq.sv | 97 +++++++++
 3 files changed

// File: rtl/wrq_pkg.sv
// Types and helpers shared by the write and read request queues of the multi-app bridge.
package wrq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_BUSY  = 2'd2
   } rq_state_t;

   function automatic int depth_of(input int add_width);
      return 2 ** add_width;
   endfunction

   function automatic bit app_id_width_ok(input int total_apps, input int id_width);
      return (2 ** id_width) >= total_apps;
   endfunction

   localparam int DEFAULT_FIFO_ADD_WIDTH = 4;
   localparam int DEPTH                  = depth_of(DEFAULT_FIFO_ADD_WIDTH);

endpackage

// File: rtl/wrq_fifo.sv
// Circular buffer of pending app ids; head is read combinationally from the read pointer.
module wrq_fifo
   import wrq_pkg::*;
#(
   parameter int WIDTH     = 3,
   parameter int ADD_WIDTH = DEFAULT_FIFO_ADD_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_push,
   input  logic [WIDTH-1:0]     i_data,
   input  logic                 i_pop,
   output logic [WIDTH-1:0]     o_head,
   output logic [ADD_WIDTH:0]   o_count,
   output logic                 o_full
);

   localparam int                 DEPTH_L    = depth_of(ADD_WIDTH);
   localparam logic [ADD_WIDTH:0] FULL_COUNT = (ADD_WIDTH + 1)'(DEPTH_L);
   localparam logic [ADD_WIDTH:0] ONE        = (ADD_WIDTH + 1)'(1);

   logic [WIDTH-1:0]     r_mem [DEPTH_L];
   logic [ADD_WIDTH-1:0] r_wr_ptr;
   logic [ADD_WIDTH-1:0] r_rd_ptr;
   logic [ADD_WIDTH:0]   r_count;
   logic                 w_push;
   logic                 w_pop;

   assign o_full  = (r_count == FULL_COUNT);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & (r_count != '0);

   // NOTE: storage is not reset; an entry is only read after it has been written, so flushing the pointers is enough.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + ONE;
            2'b01:   r_count <= r_count - ONE;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wrq.sv
// Write request queue: buffers per-app write requests and issues them in order to the shared write engine.
module wrq
   import wrq_pkg::*;
#(
   parameter int TOTAL_APPS     = 8,
   parameter int APP_ID_WIDTH   = 3,
   parameter int FIFO_ADD_WIDTH = DEFAULT_FIFO_ADD_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      write_req,
   input  logic [APP_ID_WIDTH-1:0]   req_app_id,
   output logic                      req_ready,
   input  logic [TOTAL_APPS-1:0]     data_queue_full,
   input  logic                      write_done,
   output logic                      write_queue,
   output logic [APP_ID_WIDTH-1:0]   app_id,
   output logic [FIFO_ADD_WIDTH:0]   occupants,
   output logic                      bad_id
);

   if (!app_id_width_ok(TOTAL_APPS, APP_ID_WIDTH)) begin : g_bad_cfg
      $error("wrq: APP_ID_WIDTH too narrow for TOTAL_APPS");
   end

   rq_state_t                 r_state;
   logic [APP_ID_WIDTH-1:0]   r_app_id;
   logic                      r_write_queue;
   logic                      r_bad_id;

   logic                      w_id_valid;
   logic                      w_push;
   logic                      w_pop;
   logic                      w_full;
   logic [APP_ID_WIDTH-1:0]   w_head;
   logic [FIFO_ADD_WIDTH:0]   w_count;

   assign w_id_valid = (32'(req_app_id) < TOTAL_APPS);
   assign w_push     = write_req & req_ready & w_id_valid;
   // Head-of-line blocking is deliberate: only the head may issue, which preserves per-packet order.
   assign w_pop      = (r_state == ST_CHECK) & ~data_queue_full[r_app_id];

   wrq_fifo #(
      .WIDTH     (APP_ID_WIDTH),
      .ADD_WIDTH (FIFO_ADD_WIDTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (req_app_id),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_app_id      <= '0;
         r_write_queue <= 1'b0;
         r_bad_id      <= 1'b0;
      end else begin
         r_write_queue <= 1'b0;
         if (write_req && req_ready && !w_id_valid) begin
            r_bad_id <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_count != '0) begin
                  r_app_id <= w_head;
                  r_state  <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (w_pop) begin
                  r_write_queue <= 1'b1;
                  r_state       <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (write_done) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready   = ~w_full;
   assign occupants   = w_count;
   assign write_queue = r_write_queue;
   assign app_id      = r_app_id;
   assign bad_id      = r_bad_id;

endmodule
